// File: rtl/ascon_serial_host.sv
// Bit-serial host driver for the Ascon core: takes one parallel job over
// req_valid/req_ready and feeds the operands MSB-first on the core's serial
// inputs, with fresh mask-share randomness every load cycle. It pulses the
// start strobe, waits for the core's ready (watchdog-limited), then shifts
// ciphertext and tag back in LSB-first. The result is held on rsp_valid
// until rsp_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key/nonce/ad/pt     job operands, latched when the request is accepted
//   req_valid/ready     request handshake (ready only in IDLE)
//   *xSO                serial operand + random outputs to the core
//   *xSI                serial results and done flag from the core
//   ct, tag, error      response payload, qualified by rsp_valid
//   rsp_valid/ready     response handshake
//   busy                any state other than IDLE
module ascon_serial_host #(
  parameter int          K            = 128,
  parameter int          L            = 40,
  parameter int          Y            = 40,
  parameter int          START_CYCLES = 3,
  parameter int          READ_GAP     = 2,
  parameter int          TIMEOUT      = 4096,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2357
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K-1:0]   key,
  input  logic [127:0]   nonce,
  input  logic [L-1:0]   ad,
  input  logic [Y-1:0]   pt,
  input  logic           req_valid,
  output logic           req_ready,
  output logic [2:0]     keyxSO,
  output logic [2:0]     noncexSO,
  output logic [2:0]     associated_dataxSO,
  output logic [2:0]     plain_textxSO,
  output logic [6:0]     r_64xSO,
  output logic           r_128xSO,
  output logic           r_ptxSO,
  output logic           encryption_startxSO,
  input  logic           cipher_textxSI,
  input  logic           tagxSI,
  input  logic           encryption_readyxSI,
  output logic [Y-1:0]   ct,
  output logic [127:0]   tag,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           error,
  output logic           busy
);

  localparam int MAX   = (K > L) ? ((K > Y) ? K : Y)
                                 : ((L > Y) ? L : Y);
  localparam int CMAX0 = (MAX > START_CYCLES) ? MAX : START_CYCLES;
  localparam int CMAX  = (CMAX0 > READ_GAP) ? CMAX0 : READ_GAP;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int WW    = $clog2(TIMEOUT + 1);
  localparam int GAPL  = (READ_GAP > 0) ? READ_GAP - 1 : 0;

  localparam logic [CW-1:0] LOAD_LAST  = CW'(MAX - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAPL);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0]   LFSR_TAPS  = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP, S_READ, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [31:0]    lfsr_q, lfsr_d;
  logic [K-1:0]   key_q, key_d;
  logic [127:0]   nonce_q, nonce_d;
  logic [L-1:0]   ad_q, ad_d;
  logic [Y-1:0]   pt_q, pt_d;
  logic [Y-1:0]   ct_q, ct_d;
  logic [127:0]   tag_q, tag_d;
  logic           err_q, err_d;

  logic accept;
  logic wd_expire;

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign wd_expire = (state_q == S_WAIT) && !encryption_readyxSI
                     && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      lfsr_q  <= LFSR_SEED;
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      lfsr_q  <= lfsr_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ad_q    <= ad_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_LOAD;
      S_LOAD:  if (cnt_q == LOAD_LAST) state_d = S_START;
      S_START: if (cnt_q == START_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (encryption_readyxSI)
          state_d = (READ_GAP == 0) ? S_READ : S_GAP;
        else if (wd_expire)
          state_d = S_DONE;
      end
      S_GAP:   if (cnt_q == GAP_LAST) state_d = S_READ;
      S_READ:  if (cnt_q == LOAD_LAST) state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operands are shift registers emptied MSB-first, so an
  // exhausted operand naturally drives 0. Results fill from the top and
  // land LSB-first once Y (or 128) bits have been taken.
  always_comb begin
    cnt_d   = cnt_q;
    wd_d    = '0;
    lfsr_d  = lfsr_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ad_d    = ad_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    tag_d   = tag_q;
    err_d   = err_q;

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q inside {S_LOAD, S_START, S_GAP, S_READ})
      cnt_d = cnt_q + 1'b1;

    if (state_q == S_WAIT)
      wd_d = wd_q + 1'b1;

    if (accept) begin
      key_d   = key;
      nonce_d = nonce;
      ad_d    = ad;
      pt_d    = pt;
      err_d   = 1'b0;
    end

    if (state_q == S_LOAD) begin
      lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
      key_d   = {key_q[K-2:0], 1'b0};
      nonce_d = {nonce_q[126:0], 1'b0};
      ad_d    = {ad_q[L-2:0], 1'b0};
      pt_d    = {pt_q[Y-2:0], 1'b0};
    end

    if (wd_expire) begin
      ct_d  = '0;
      tag_d = '0;
      err_d = 1'b1;
    end

    if (state_q == S_READ) begin
      if (int'(cnt_q) < Y)
        ct_d = {cipher_textxSI, ct_q[Y-1:1]};
      if (int'(cnt_q) < 128)
        tag_d = {tagxSI, tag_q[127:1]};
    end

    if ((state_q == S_DONE) && rsp_ready)
      err_d = 1'b0;
  end

  always_comb begin
    req_ready           = (state_q == S_IDLE);
    busy                = (state_q != S_IDLE);
    rsp_valid           = (state_q == S_DONE);
    encryption_startxSO = (state_q == S_START);
    error               = err_q;
    ct                  = ct_q;
    tag                 = tag_q;
    keyxSO              = '0;
    noncexSO            = '0;
    associated_dataxSO  = '0;
    plain_textxSO       = '0;
    r_64xSO             = '0;
    r_ptxSO             = 1'b0;
    r_128xSO            = 1'b0;
    if (state_q == S_LOAD) begin
      noncexSO           = {lfsr_q[1:0], nonce_q[127]};
      plain_textxSO      = {lfsr_q[3:2], pt_q[Y-1]};
      associated_dataxSO = {lfsr_q[5:4], ad_q[L-1]};
      keyxSO             = {lfsr_q[7:6], key_q[K-1]};
      r_64xSO            = lfsr_q[14:8];
      r_ptxSO            = lfsr_q[15];
      r_128xSO           = lfsr_q[16];
    end
  end

endmodule

// File: tb/tb_ascon_serial_host.sv
// Directed + randomized bench for ascon_serial_host with a behavioural
// core model and an operand/LFSR reference computed from first principles.
module tb_ascon_serial_host;

  localparam int          K     = 128;
  localparam int          L     = 40;
  localparam int          Y     = 40;
  localparam int          SC    = 3;
  localparam int          RG    = 2;
  localparam int          TO    = 4096;
  localparam int          MAX   = 128;
  localparam logic [31:0] SEED  = 32'hACE1_2357;
  localparam int          NEVER = 1 << 30;

  logic           clk = 1'b0;
  logic           rst;
  logic [K-1:0]   key;
  logic [127:0]   nonce;
  logic [L-1:0]   ad;
  logic [Y-1:0]   pt;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     keyxSO;
  logic [2:0]     noncexSO;
  logic [2:0]     associated_dataxSO;
  logic [2:0]     plain_textxSO;
  logic [6:0]     r_64xSO;
  logic           r_128xSO;
  logic           r_ptxSO;
  logic           encryption_startxSO;
  logic           cipher_textxSI;
  logic           tagxSI;
  logic           encryption_readyxSI;
  logic [Y-1:0]   ct;
  logic [127:0]   tag;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           error;
  logic           busy;

  ascon_serial_host #(
    .K(K), .L(L), .Y(Y), .START_CYCLES(SC), .READ_GAP(RG),
    .TIMEOUT(TO), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .nonce(nonce), .ad(ad), .pt(pt),
    .req_valid(req_valid), .req_ready(req_ready),
    .keyxSO(keyxSO), .noncexSO(noncexSO),
    .associated_dataxSO(associated_dataxSO),
    .plain_textxSO(plain_textxSO), .r_64xSO(r_64xSO),
    .r_128xSO(r_128xSO), .r_ptxSO(r_ptxSO),
    .encryption_startxSO(encryption_startxSO),
    .cipher_textxSI(cipher_textxSI), .tagxSI(tagxSI),
    .encryption_readyxSI(encryption_readyxSI),
    .ct(ct), .tag(tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mlfsr;

  task automatic chk(input string t, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic logic [16:0] rnd_obs();
    return {r_128xSO, r_ptxSO, r_64xSO, keyxSO[2:1],
            associated_dataxSO[2:1], plain_textxSO[2:1], noncexSO[2:1]};
  endfunction

  function automatic logic [3:0] dat_obs();
    return {keyxSO[0], noncexSO[0], associated_dataxSO[0],
            plain_textxSO[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(
    input logic [K-1:0] k_i, input logic [127:0] n_i,
    input logic [L-1:0] a_i, input logic [Y-1:0] p_i,
    input int rdy_at, input logic [MAX-1:0] cv, input logic [MAX-1:0] tv,
    input int hold, input int abort_at);
    logic [3:0]   ed;
    logic [Y-1:0] ect;
    logic [127:0] etag;
    logic         eerr;
    int           rdy_seen, exp_done, idx;
    bit           done;
    key = k_i; nonce = n_i; ad = a_i; pt = p_i;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    key = '0; nonce = '0; ad = '0; pt = '0;
    chk("accept_hs", {busy, req_ready}, 2'b10);
    for (int c = 0; c < MAX; c++) begin
      ed[3] = (c < K) ? k_i[K-1-c] : 1'b0;
      ed[2] = n_i[127-c];
      ed[1] = (c < L) ? a_i[L-1-c] : 1'b0;
      ed[0] = (c < Y) ? p_i[Y-1-c] : 1'b0;
      chk($sformatf("load_data[%0d]", c), dat_obs(), ed);
      chk($sformatf("load_rnd[%0d]", c), rnd_obs(), mlfsr[16:0]);
      if (c == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        mlfsr = SEED;
        chk("abort_idle", {busy, req_ready, rsp_valid,
                           encryption_startxSO, error}, 5'b01000);
        chk("abort_serial", {rnd_obs(), dat_obs()}, 0);
        return;
      end
      mlfsr = lfsr_next(mlfsr);
      step();
    end
    rdy_seen = (rdy_at < SC) ? SC : rdy_at;
    exp_done = (rdy_at >= NEVER) ? SC + TO : rdy_seen + 1 + RG + MAX;
    done = 0;
    for (int sc = 0; sc < SC + TO + MAX + 64 && !done; sc++) begin
      encryption_readyxSI = (sc >= rdy_at);
      idx = sc - rdy_seen - 1 - RG;
      cipher_textxSI = (idx >= 0 && idx < MAX) ? cv[idx] : 1'b0;
      tagxSI         = (idx >= 0 && idx < MAX) ? tv[idx] : 1'b0;
      if (sc < SC) begin
        chk("start_hi", encryption_startxSO, 1);
        chk("start_quiet", {rnd_obs(), dat_obs()}, 0);
      end
      if (sc == SC) chk("wait_start_lo", encryption_startxSO, 0);
      if (rsp_valid) begin
        chk("done_cycle", sc, exp_done);
        done = 1;
      end else begin
        step();
      end
    end
    chk("done_seen", done, 1);
    encryption_readyxSI = 1'b0;
    cipher_textxSI = 1'b0;
    tagxSI = 1'b0;
    if (rdy_at >= NEVER) begin
      ect = '0; etag = '0; eerr = 1'b1;
    end else begin
      ect = cv[Y-1:0]; etag = tv[127:0]; eerr = 1'b0;
    end
    chk("rsp_ct", ct, ect);
    chk("rsp_tag", tag, etag);
    chk("rsp_err", error, eerr);
    for (int h = 0; h < hold; h++) begin
      req_valid = (h == hold / 2);
      step();
      chk("hold_ct", ct, ect);
      chk("hold_tag", tag, etag);
      chk("hold_hs", {rsp_valid, req_ready, busy, error},
          {3'b101, eerr});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("release_hs", {rsp_valid, req_ready, busy, error}, 4'b0100);
    step();
    chk("idle_stays", {req_ready, busy}, 2'b10);
  endtask

  initial begin
    logic [K-1:0]   k0;
    logic [127:0]   n0;
    logic [L-1:0]   a0;
    logic [Y-1:0]   p0;
    logic [MAX-1:0] cv0, tv0, cvr, tvr;
    rst = 1'b1;
    key = '0; nonce = '0; ad = '0; pt = '0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    cipher_textxSI = 1'b0; tagxSI = 1'b0; encryption_readyxSI = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    mlfsr = SEED;
    repeat (10) step();
    chk("rst_hs", {req_ready, busy, rsp_valid, error,
                   encryption_startxSO}, 5'b10000);
    chk("rst_serial", {rnd_obs(), dat_obs()}, 0);
    chk("rst_ct", ct, 0);
    chk("rst_tag", tag, 0);

    k0 = 128'h2db083053e848cefa30007336c47a5a1;
    n0 = 128'h3f3607dbce3503ba84f5843d623de056;
    a0 = 40'h4153434f4e;
    p0 = 40'h6173636f6e;
    for (int i = 0; i < MAX; i++) begin
      cv0[i] = i[0];
      tv0[i] = ~i[0];
    end
    run_job(k0, n0, a0, p0, 500, cv0, tv0, 20, -1);

    cvr = {$urandom, $urandom, $urandom, $urandom};
    tvr = {$urandom, $urandom, $urandom, $urandom};
    run_job({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom},
            0, cvr, tvr, 3, -1);

    cvr = {$urandom, $urandom, $urandom, $urandom};
    tvr = {$urandom, $urandom, $urandom, $urandom};
    run_job({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom},
            int'($urandom_range(4, 120)), cvr, tvr, 1, -1);

    run_job(k0, n0, a0, p0, NEVER, cv0, tv0, 2, -1);

    run_job(k0, n0, a0, p0, 500, cv0, tv0, 0, 60);
    run_job(k0, n0, a0, p0, 7, cv0, tv0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
